// File: rtl/watchdog_timer_ctrl_if.sv
// Control/status bundle between software/driver side and the watchdog sequencer.
interface watchdog_timer_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic                 pause;
  logic                 kick;
  logic                 cfg_we;
  logic [CNT_WIDTH-1:0] cfg_warn;
  logic [CNT_WIDTH-1:0] cfg_bite;
  logic                 delta;
  logic                 freeze;
  logic                 warn_irq;
  logic                 sys_rst_req;
  logic                 bite_seen;
  logic                 cfg_err;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] count;

  modport master (
    output enable, pause, kick, cfg_we, cfg_warn, cfg_bite, delta,
    input  freeze, warn_irq, sys_rst_req, bite_seen, cfg_err, state, count
  );

  modport slave (
    input  enable, pause, kick, cfg_we, cfg_warn, cfg_bite, delta,
    output freeze, warn_irq, sys_rst_req, bite_seen, cfg_err, state, count
  );
endinterface

// File: rtl/watchdog_timer_ctrl.sv
// Watchdog sequencer: counts consecutive stall cycles, warns, then requests a reset pulse.
// All outputs registered except freeze (decoded from state and pause).
module watchdog_timer_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int RST_PULSE = 4
) (
  input  logic                clk,
  input  logic                rstn,
  watchdog_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_ARMED    = 2'd1,
    S_WARN     = 2'd2,
    S_BITE     = 2'd3
  } state_e;

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);
  localparam logic [CNT_WIDTH-1:0] WARN_DEF = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] BITE_DEF = '1;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] warn_lim_q, warn_lim_d;
  logic [CNT_WIDTH-1:0] bite_lim_q, bite_lim_d;
  logic [PW-1:0]        pulse_q, pulse_d;
  logic                 warn_irq_q, warn_irq_d;
  logic                 sys_rst_q, sys_rst_d;
  logic                 bite_seen_q, bite_seen_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [CNT_WIDTH-1:0] count_inc;
  logic                 cfg_ok;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    warn_lim_d  = warn_lim_q;
    bite_lim_d  = bite_lim_q;
    pulse_d     = pulse_q;
    warn_irq_d  = 1'b0;
    sys_rst_d   = 1'b0;
    bite_seen_d = bite_seen_q;
    cfg_err_d   = 1'b0;
    count_inc   = count_q + 1'b1;
    cfg_ok      = (state_q == S_DISABLED) && (bus.cfg_warn != '0) &&
                  (bus.cfg_warn < bus.cfg_bite);

    if (bus.cfg_we) begin
      if (cfg_ok) begin
        warn_lim_d = bus.cfg_warn;
        bite_lim_d = bus.cfg_bite;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      S_DISABLED: begin
        count_d = '0;
        if (bus.enable) begin
          state_d     = S_ARMED;
          bite_seen_d = 1'b0;
        end
      end
      S_ARMED, S_WARN: begin
        if (!bus.enable) begin
          state_d = S_DISABLED;
          count_d = '0;
        end else if (bus.kick) begin
          state_d = S_ARMED;
          count_d = '0;
        end else if (bus.pause) begin
          state_d = state_q;
        end else if (!bus.delta) begin
          state_d = S_ARMED;
          count_d = '0;
        end else begin
          // saturate at the bite limit so the counter can never wrap
          if (count_q < bite_lim_q) count_d = count_inc;
          if (state_q == S_WARN && count_inc >= bite_lim_q) begin
            state_d     = S_BITE;
            pulse_d     = PULSE_LAST;
            sys_rst_d   = 1'b1;
            bite_seen_d = 1'b1;
          end else if (state_q == S_ARMED && count_inc >= warn_lim_q) begin
            state_d    = S_WARN;
            warn_irq_d = 1'b1;
          end
        end
      end
      S_BITE: begin
        if (pulse_q == '0) begin
          state_d = S_DISABLED;
          count_d = '0;
        end else begin
          pulse_d   = pulse_q - 1'b1;
          sys_rst_d = 1'b1;
        end
      end
      default: begin
        state_d = S_DISABLED;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_DISABLED;
      count_q     <= '0;
      warn_lim_q  <= WARN_DEF;
      bite_lim_q  <= BITE_DEF;
      pulse_q     <= '0;
      warn_irq_q  <= 1'b0;
      sys_rst_q   <= 1'b0;
      bite_seen_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      warn_lim_q  <= warn_lim_d;
      bite_lim_q  <= bite_lim_d;
      pulse_q     <= pulse_d;
      warn_irq_q  <= warn_irq_d;
      sys_rst_q   <= sys_rst_d;
      bite_seen_q <= bite_seen_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.freeze      = (state_q == S_ARMED || state_q == S_WARN) ? bus.pause : 1'b1;
  assign bus.warn_irq    = warn_irq_q;
  assign bus.sys_rst_req = sys_rst_q;
  assign bus.bite_seen   = bite_seen_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.state       = state_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_watchdog_timer_ctrl.sv
// Directed bench: expected outputs are queued per step and compared after each clock edge.
module tb_watchdog_timer_ctrl;

  localparam logic [1:0] D = 2'd0, A = 2'd1, W = 2'd2, B = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] cnt;
    logic       wi;
    logic       sr;
    logic       bs;
    logic       ce;
    logic       fz;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  watchdog_timer_ctrl_if #(.CNT_WIDTH(4)) wif ();

  watchdog_timer_ctrl #(.CNT_WIDTH(4), .RST_PULSE(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (wif)
  );

  task automatic cmp(input string name, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp({t, ".state"},  {6'd0, wif.state},       {6'd0, e.st});
    cmp({t, ".count"},  {4'd0, wif.count},       {4'd0, e.cnt});
    cmp({t, ".warn"},   {7'd0, wif.warn_irq},    {7'd0, e.wi});
    cmp({t, ".sysrst"}, {7'd0, wif.sys_rst_req}, {7'd0, e.sr});
    cmp({t, ".bseen"},  {7'd0, wif.bite_seen},   {7'd0, e.bs});
    cmp({t, ".cfgerr"}, {7'd0, wif.cfg_err},     {7'd0, e.ce});
    cmp({t, ".freeze"}, {7'd0, wif.freeze},      {7'd0, e.fz});
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                      input logic wi, input logic sr, input logic bs, input logic ce,
                      input logic fz);
    exp_t e;
    e = '{st: st, cnt: cnt, wi: wi, sr: sr, bs: bs, ce: ce, fz: fz};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic step(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                      input logic wi, input logic sr, input logic bs, input logic ce,
                      input logic fz);
    push(tag, st, cnt, wi, sr, bs, ce, fz);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic check_now(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                           input logic wi, input logic sr, input logic bs, input logic ce,
                           input logic fz);
    push(tag, st, cnt, wi, sr, bs, ce, fz);
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    wif.enable = 0; wif.pause = 0; wif.kick = 0; wif.cfg_we = 0;
    wif.cfg_warn = 4'd0; wif.cfg_bite = 4'd0; wif.delta = 0;
    #2;
    check_now("reset", D, 0, 0, 0, 0, 0, 1);
    #10 rstn = 1'b1;

    // full run to bite with warn=3, bite=5
    wif.cfg_we = 1; wif.cfg_warn = 4'd3; wif.cfg_bite = 4'd5;
    step("cfg_ok", D, 0, 0, 0, 0, 0, 1);
    wif.cfg_we = 0; wif.enable = 1; wif.delta = 1;
    step("arm", A, 0, 0, 0, 0, 0, 0);
    step("st1", A, 1, 0, 0, 0, 0, 0);
    step("st2", A, 2, 0, 0, 0, 0, 0);
    step("warn", W, 3, 1, 0, 0, 0, 0);
    step("st4", W, 4, 0, 0, 0, 0, 0);
    step("bite1", B, 5, 0, 1, 1, 0, 1);
    for (int i = 2; i <= 4; i++) step($sformatf("bite%0d", i), B, 5, 0, 1, 1, 0, 1);
    step("post_bite", D, 0, 0, 0, 1, 0, 1);
    step("rearm", A, 0, 0, 0, 0, 0, 0);

    // kick in WARN, delta=0 clears, warn re-pulses
    step("k_st1", A, 1, 0, 0, 0, 0, 0);
    step("k_st2", A, 2, 0, 0, 0, 0, 0);
    step("k_warn", W, 3, 1, 0, 0, 0, 0);
    wif.kick = 1;
    step("kick", A, 0, 0, 0, 0, 0, 0);
    wif.kick = 0;
    step("d_st1", A, 1, 0, 0, 0, 0, 0);
    step("d_st2", A, 2, 0, 0, 0, 0, 0);
    wif.delta = 0;
    step("delta0", A, 0, 0, 0, 0, 0, 0);
    wif.delta = 1;
    step("r_st1", A, 1, 0, 0, 0, 0, 0);
    step("r_st2", A, 2, 0, 0, 0, 0, 0);
    step("rewarn", W, 3, 1, 0, 0, 0, 0);
    wif.enable = 0;
    step("dis1", D, 0, 0, 0, 0, 0, 1);

    // pause holds count and freezes the driver
    wif.enable = 1;
    step("p_arm", A, 0, 0, 0, 0, 0, 0);
    step("p_st1", A, 1, 0, 0, 0, 0, 0);
    step("p_st2", A, 2, 0, 0, 0, 0, 0);
    wif.pause = 1;
    for (int i = 0; i < 10; i++) step($sformatf("pause%0d", i), A, 2, 0, 0, 0, 0, 1);
    wif.pause = 0;
    step("p_warn", W, 3, 1, 0, 0, 0, 0);
    wif.pause = 1;
    for (int i = 0; i < 3; i++) step($sformatf("wpause%0d", i), W, 3, 0, 0, 0, 0, 1);
    wif.pause = 0;
    step("p_st4", W, 4, 0, 0, 0, 0, 0);
    // disable coincides with the edge that would have reached bite
    wif.enable = 0;
    step("dis_wins", D, 0, 0, 0, 0, 0, 1);
    step("dis_hold", D, 0, 0, 0, 0, 0, 1);

    // rejected config writes
    wif.enable = 1;
    step("c_arm", A, 0, 0, 0, 0, 0, 0);
    wif.delta = 0; wif.cfg_we = 1; wif.cfg_warn = 4'd1; wif.cfg_bite = 4'd2;
    step("cfg_armed", A, 0, 0, 0, 0, 1, 0);
    wif.cfg_we = 0;
    step("cfg_clr", A, 0, 0, 0, 0, 0, 0);
    wif.enable = 0;
    step("c_dis", D, 0, 0, 0, 0, 0, 1);
    wif.cfg_we = 1; wif.cfg_warn = 4'd5; wif.cfg_bite = 4'd5;
    step("cfg_eq", D, 0, 0, 0, 0, 1, 1);
    wif.cfg_warn = 4'd0; wif.cfg_bite = 4'd5;
    step("cfg_zero", D, 0, 0, 0, 0, 1, 1);
    wif.cfg_we = 0;
    step("cfg_clr2", D, 0, 0, 0, 0, 0, 1);
    wif.enable = 1; wif.delta = 1;
    step("c_arm2", A, 0, 0, 0, 0, 0, 0);
    step("c_st1", A, 1, 0, 0, 0, 0, 0);
    step("c_st2", A, 2, 0, 0, 0, 0, 0);
    step("c_warn", W, 3, 1, 0, 0, 0, 0);
    step("c_st4", W, 4, 0, 0, 0, 0, 0);
    step("c_bite1", B, 5, 0, 1, 1, 0, 1);
    step("c_bite2", B, 5, 0, 1, 1, 0, 1);

    // async reset in the middle of BITE
    #1 rstn = 1'b0;
    #1;
    check_now("mid_rst", D, 0, 0, 0, 0, 0, 1);
    wif.enable = 0;
    #3 rstn = 1'b1;

    // default limits after reset: warn 8, bite 15
    wif.enable = 1;
    step("d_arm", A, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) step($sformatf("dflt%0d", i), A, 4'(i), 0, 0, 0, 0, 0);
    step("dflt_warn", W, 8, 1, 0, 0, 0, 0);
    for (int i = 9; i <= 14; i++) step($sformatf("dflt%0d", i), W, 4'(i), 0, 0, 0, 0, 0);
    step("dflt_bite", B, 15, 0, 1, 1, 0, 1);
    for (int i = 2; i <= 4; i++) step($sformatf("dbite%0d", i), B, 15, 0, 1, 1, 0, 1);
    step("d_post", D, 0, 0, 0, 1, 0, 1);
    step("d_rearm", A, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
